// File: rtl/hazard_stall_controller.sv
// Load-use / taken-branch hazard sequencer for the 5-stage pipeline with Mealy stall, flush and bubble outputs.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall_cycles / flush_cycles counters.
module hazard_stall_controller #(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned LOAD_BUBBLES = 1,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  stall_flag_if,
    output logic                  stall_flag_id,
    output logic                  stall_flag_ex,
    output logic                  busy
`ifdef HAZARD_PERF_CNT_EN
   ,output logic [15:0]           stall_cycles,
    output logic [15:0]           flush_cycles
`endif
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2
    } state_e;

    // Counter preloads: number of further cycles to spend after the entry cycle.
    localparam logic [1:0] LOAD_RELOAD  = (LOAD_BUBBLES > 1) ? 2'(LOAD_BUBBLES - 2) : 2'd0;
    localparam logic [1:0] FLUSH_RELOAD = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       hazard;
    logic       stall_c, flush_c;

    assign hazard = ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = 1'b0;
        flush_c = 1'b0;
        unique case (state_q)
            RUN: begin
                if (ex_branch_taken) begin
                    flush_c = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        cnt_d   = FLUSH_RELOAD;
                    end
                end else if (hazard) begin
                    stall_c = 1'b1;
                    if (LOAD_BUBBLES > 1) begin
                        state_d = LOAD_STALL;
                        cnt_d   = LOAD_RELOAD;
                    end
                end
            end
            LOAD_STALL: begin
                if (ex_branch_taken) begin
                    flush_c = 1'b1;
                    state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                    cnt_d   = FLUSH_RELOAD;
                end else begin
                    stall_c = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
            end
            FLUSH: begin
                // Hazards are ignored: the instruction in ID is being squashed anyway.
                flush_c = 1'b1;
                if (ex_branch_taken) begin
                    cnt_d = FLUSH_RELOAD;
                end else if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Every output is forced low while reset is asserted.
    assign pc_stall      = !reset && stall_c;
    assign if_id_stall   = !reset && stall_c;
    assign if_id_flush   = !reset && flush_c;
    assign id_ex_bubble  = !reset && (stall_c || flush_c);
    assign busy          = !reset && (state_q != RUN);
    assign stall_flag_if = pc_stall;
    assign stall_flag_id = if_id_stall || if_id_flush;
    assign stall_flag_ex = id_ex_bubble;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cycles_q;
    logic [15:0] flush_cycles_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_cycles_q <= '0;
        end else begin
            if (pc_stall && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + 16'd1;
            end
            if (if_id_flush && (flush_cycles_q != '1)) begin
                flush_cycles_q <= flush_cycles_q + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_cycles = flush_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: four parameter sets share one stimulus stream, checked every cycle
// against a remaining-cycles model plus directed literal expectations.
module tb_hazard_stall_controller;

    localparam int unsigned NDUT = 4;
    localparam int unsigned LB_TAB [NDUT] = '{1, 3, 2, 1};
    localparam int unsigned FC_TAB [NDUT] = '{2, 2, 3, 1};

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rt, ex_mem_read, ex_branch_taken;

    logic pc_stall_w [NDUT];
    logic if_id_stall_w [NDUT];
    logic if_id_flush_w [NDUT];
    logic id_ex_bubble_w [NDUT];
    logic sf_if_w [NDUT];
    logic sf_id_w [NDUT];
    logic sf_ex_w [NDUT];
    logic busy_w [NDUT];
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] sc_w [NDUT];
    logic [15:0] fc_w [NDUT];
`endif

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;
    int stall_left [NDUT];
    int flush_left [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : gen_dut
        hazard_stall_controller #(
            .REG_ADDR_W  (5),
            .LOAD_BUBBLES(LB_TAB[g]),
            .FLUSH_CYCLES(FC_TAB[g])
        ) u_dut (
            .clk            (clk),
            .reset          (reset),
            .id_rs          (id_rs),
            .id_rt          (id_rt),
            .id_uses_rt     (id_uses_rt),
            .ex_mem_read    (ex_mem_read),
            .ex_rd          (ex_rd),
            .ex_branch_taken(ex_branch_taken),
            .pc_stall       (pc_stall_w[g]),
            .if_id_stall    (if_id_stall_w[g]),
            .if_id_flush    (if_id_flush_w[g]),
            .id_ex_bubble   (id_ex_bubble_w[g]),
            .stall_flag_if  (sf_if_w[g]),
            .stall_flag_id  (sf_id_w[g]),
            .stall_flag_ex  (sf_ex_w[g]),
            .busy           (busy_w[g])
`ifdef HAZARD_PERF_CNT_EN
           ,.stall_cycles   (sc_w[g]),
            .flush_cycles   (fc_w[g])
`endif
        );
    end

    task automatic check(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each DUT owes some number of further stall or flush cycles; branch beats everything.
    always @(negedge clk) begin
        bit hz, e_pc, e_fl, e_busy;
        if (model_on) begin
            hz = ex_mem_read && (ex_rd != 0) &&
                 ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
            for (int d = 0; d < NDUT; d++) begin
                e_pc   = 1'b0;
                e_fl   = 1'b0;
                e_busy = !reset && (flush_left[d] > 0 || stall_left[d] > 0);
                if (reset) begin
                    flush_left[d] = 0;
                    stall_left[d] = 0;
                end else if (ex_branch_taken) begin
                    e_fl = 1'b1;
                    flush_left[d] = int'(FC_TAB[d]) - 1;
                    stall_left[d] = 0;
                end else if (flush_left[d] > 0) begin
                    e_fl = 1'b1;
                    flush_left[d]--;
                end else if (stall_left[d] > 0) begin
                    e_pc = 1'b1;
                    stall_left[d]--;
                end else if (hz) begin
                    e_pc = 1'b1;
                    stall_left[d] = int'(LB_TAB[d]) - 1;
                end
                check($sformatf("d%0d_pc_stall", d), pc_stall_w[d], e_pc);
                check($sformatf("d%0d_if_id_stall", d), if_id_stall_w[d], e_pc);
                check($sformatf("d%0d_if_id_flush", d), if_id_flush_w[d], e_fl);
                check($sformatf("d%0d_id_ex_bubble", d), id_ex_bubble_w[d], e_pc | e_fl);
                check($sformatf("d%0d_stall_flag_if", d), sf_if_w[d], e_pc);
                check($sformatf("d%0d_stall_flag_id", d), sf_id_w[d], e_pc | e_fl);
                check($sformatf("d%0d_stall_flag_ex", d), sf_ex_w[d], e_pc | e_fl);
                check($sformatf("d%0d_busy", d), busy_w[d], e_busy);
            end
        end
    end

    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic mr, input logic [4:0] rd, input logic br);
        @(posedge clk);
        #1;
        id_rs = rs; id_rt = rt; id_uses_rt = urt;
        ex_mem_read = mr; ex_rd = rd; ex_branch_taken = br;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    // Literal expectation of one DUT's main outputs.
    task automatic expect4(input string nm, input int d, input logic pc, input logic fl,
                           input logic bb);
        check({nm, "_pc_stall"}, pc_stall_w[d], pc);
        check({nm, "_if_id_stall"}, if_id_stall_w[d], pc);
        check({nm, "_if_id_flush"}, if_id_flush_w[d], fl);
        check({nm, "_busy"}, busy_w[d], bb);
    endtask

    initial begin
        reset = 1'b1;
        id_rs = 5'd8; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b1; ex_rd = 5'd8; ex_branch_taken = 1'b0;
        @(posedge clk);
        #1;
        model_on = 1'b1;
        @(negedge clk);
        #1;
        expect4("reset_hazard", 0, 1'b0, 1'b0, 1'b0);
        check("reset_bubble", id_ex_bubble_w[0], 1'b0);

        @(posedge clk);
        #1;
        reset = 1'b0;
        ex_mem_read = 1'b0;
        @(negedge clk);
        #1;
        expect4("idle_after_reset", 0, 1'b0, 1'b0, 1'b0);

        // Load-use on rs: one bubble for LB=1, three for LB=3.
        step(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0);
        expect4("lu_rs_c0_lb1", 0, 1'b1, 1'b0, 1'b0);
        check("lu_rs_c0_bubble", id_ex_bubble_w[0], 1'b1);
        expect4("lu_rs_c0_lb3", 1, 1'b1, 1'b0, 1'b0);
        idle(1);
        expect4("lu_rs_c1_lb1", 0, 1'b0, 1'b0, 1'b0);
        expect4("lu_rs_c1_lb3", 1, 1'b1, 1'b0, 1'b1);
        idle(1);
        expect4("lu_rs_c2_lb3", 1, 1'b1, 1'b0, 1'b1);
        idle(1);
        expect4("lu_rs_c3_lb3", 1, 1'b0, 1'b0, 1'b0);

        // Register zero and unused rt never stall; used rt does.
        step(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
        expect4("reg_zero", 0, 1'b0, 1'b0, 1'b0);
        step(5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0);
        expect4("rt_unused", 0, 1'b0, 1'b0, 1'b0);
        step(5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0);
        expect4("rt_used", 0, 1'b1, 1'b0, 1'b0);
        idle(3);

        // Taken branch, FLUSH_CYCLES=2.
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        expect4("br_c0", 0, 1'b0, 1'b1, 1'b0);
        check("br_c0_bubble", id_ex_bubble_w[0], 1'b1);
        idle(1);
        expect4("br_c1", 0, 1'b0, 1'b1, 1'b1);
        idle(1);
        expect4("br_c2", 0, 1'b0, 1'b0, 1'b0);
        expect4("br_c2_fc3", 2, 1'b0, 1'b1, 1'b1);
        idle(1);

        // Branch during a 3-bubble stall; branch arrives together with the hazard.
        step(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0);
        expect4("bds_c0", 1, 1'b1, 1'b0, 1'b0);
        step(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1);
        expect4("bds_c1", 1, 1'b0, 1'b1, 1'b1);
        idle(1);
        expect4("bds_c2", 1, 1'b0, 1'b1, 1'b1);
        idle(1);
        expect4("bds_c3", 1, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Reset in the second flush cycle, then a hazard is seen normally.
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1; ex_branch_taken = 1'b0;
        @(negedge clk);
        #1;
        expect4("rst_flush_c1", 0, 1'b0, 1'b0, 1'b0);
        check("rst_flush_c1_bubble", id_ex_bubble_w[0], 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        expect4("rst_flush_c2", 0, 1'b0, 1'b0, 1'b0);
        step(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0);
        expect4("rst_then_hazard", 0, 1'b1, 1'b0, 1'b0);
        idle(3);

        // Repeated branch during FLUSH reloads the counter (FC=3 DUT).
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        idle(1);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        idle(1);
        expect4("reload_fc3", 2, 1'b0, 1'b1, 1'b1);
        idle(3);

        // Mixed traffic with frequent hazards, branches and occasional reset.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            id_uses_rt = 1'($urandom_range(0, 1));
            ex_mem_read = 1'($urandom_range(0, 1));
            ex_rd = 5'($urandom_range(0, 3));
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 39) == 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(4);

`ifdef HAZARD_PERF_CNT_EN
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0);
            idle(1);
        end
        for (int i = 0; i < 2; i++) begin
            step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
            idle(2);
        end
        check16("perf_stall_cycles", sc_w[0], 16'd3);
        check16("perf_flush_cycles", fc_w[0], 16'd4);
        @(posedge clk);
        #1;
        force gen_dut[0].u_dut.stall_cycles_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release gen_dut[0].u_dut.stall_cycles_q;
        for (int i = 0; i < 3; i++) step(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0);
        idle(1);
        check16("perf_stall_saturate", sc_w[0], 16'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
Central hazard sequencer for the 5-stage pipeline (IF, ID, EX, DM, WB).
- Detects load-use hazards between ID and EX and freezes PC and IF/ID while bubbling ID/EX.
- Squashes wrong-path instructions after a taken branch resolved in EX.
- Drives the per-stage stall flags (if/id/ex) consumed by the fetch, decode and execute units, replacing ad-hoc flag looping between stages.

Parameters:
REG_ADDR_W, 5, register address width
LOAD_BUBBLES, 1, bubbles inserted per load-use hazard (legal 1..3)
FLUSH_CYCLES, 2, cycles of squash after a taken branch (legal 1..3)

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  synchronous, active-high
id_rs  input  REG_ADDR_W  rs field of instruction in ID
id_rt  input  REG_ADDR_W  rt field of instruction in ID
id_uses_rt  input  1  ID instruction reads rt (R-type, store, beq)
ex_mem_read  input  1  instruction in EX is a load
ex_rd  input  REG_ADDR_W  destination register of instruction in EX
ex_branch_taken  input  1  branch in EX resolved taken this cycle
pc_stall  output  1  hold PC
if_id_stall  output  1  hold IF/ID register
if_id_flush  output  1  clear IF/ID to NOP
id_ex_bubble  output  1  zero all control bits entering ID/EX
stall_flag_if  output  1  equals pc_stall
stall_flag_id  output  1  equals if_id_stall | if_id_flush
stall_flag_ex  output  1  equals id_ex_bubble
busy  output  1  FSM not in RUN

Behaviour:
- States: RUN, LOAD_STALL, FLUSH. 2-bit counter cnt. All state changes occur on the rising edge of clk.
- Reset, including mid-stall or mid-flush: next edge goes to RUN with cnt=0. While reset is high, every output is 0.
- hazard = ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt))). Register 0 never causes a hazard.
- Outputs are Mealy: a combinational function of state and the current inputs, so the response is visible in the same cycle (zero latency).
- RUN:
  - If ex_branch_taken: if_id_flush=1, id_ex_bubble=1, pc_stall=0 (the PC loads the target). If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-2; otherwise stay in RUN.
  - Else if hazard: pc_stall=1, if_id_stall=1, id_ex_bubble=1. If LOAD_BUBBLES>1, go to LOAD_STALL with cnt=LOAD_BUBBLES-2; otherwise stay in RUN.
  - Else: all outputs 0.
- LOAD_STALL: pc_stall=1, if_id_stall=1, id_ex_bubble=1, busy=1.
  - If cnt==0, go to RUN; else cnt decrements.
  - If ex_branch_taken arrives: the branch wins. Outputs are the same as the RUN branch case, and the FSM enters FLUSH (or RUN when FLUSH_CYCLES==1).
- FLUSH: if_id_flush=1, id_ex_bubble=1, pc_stall=0, if_id_stall=0, busy=1.
  - If cnt==0, go to RUN; else cnt decrements.
  - A hazard is ignored here, because the ID instruction is being squashed.
  - A new ex_branch_taken reloads cnt=FLUSH_CYCLES-2. This case cannot occur legally; it is covered defensively.
- Simultaneous branch taken and hazard in any state: the branch has priority and the load-use stall is dropped.
- if_id_stall and if_id_flush are never both 1.
- The counter never wraps: cnt only decrements toward 0.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds outputs stall_cycles[15:0] and flush_cycles[15:0].
  - stall_cycles counts cycles with pc_stall=1; flush_cycles counts cycles with if_id_flush=1.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: neither port nor the counters exist.
- Hazard and flush behaviour is identical in both builds.

Test Plan:
- Load-use on rs: ex_mem_read=1, ex_rd=8, id_rs=8, LOAD_BUBBLES=1 -> pc_stall, if_id_stall and id_ex_bubble are 1 for exactly 1 cycle, then 0; busy stays 0.
- Register zero and unused rt: ex_rd=0 with id_rs=0; then ex_rd=9, id_rt=9, id_uses_rt=0 -> no stall asserted in either case.
- Taken branch, FLUSH_CYCLES=2: pulse ex_branch_taken for 1 cycle -> if_id_flush and id_ex_bubble are 1 for 2 consecutive cycles, pc_stall stays 0, busy=1 in the 2nd cycle.
- Branch during stall, LOAD_BUBBLES=3: hazard in cycle 0, ex_branch_taken in cycle 1 -> cycle 0 stall; cycles 1-2 flush, pc_stall=0; RUN by cycle 3.
- Reset mid-flush: assert reset in the 2nd flush cycle -> all outputs 0 that cycle and the following cycle, FSM in RUN; a subsequent hazard is detected normally.
- With HAZARD_PERF_CNT_EN defined: 3 hazards plus 2 branches at default parameters -> stall_cycles=3, flush_cycles=4. Preload 16'hFFFE, then stall for 3 cycles -> stall_cycles holds at 16'hFFFF.
